// File: rtl/codificador_pkg.sv
// Shared constants for the position-code encoder: code words, position
// encodings, controller states and small classification helpers.
package codificador_pkg;

  // Seven-bit code words sent to the decoder
  localparam logic [6:0] COD_POS1   = 7'b1100000;
  localparam logic [6:0] COD_POS2   = 7'b1000100;
  localparam logic [6:0] COD_POS3   = 7'b1111100;
  localparam logic [6:0] COD_POS4   = 7'b1011010;
  localparam logic [6:0] COD_POS5   = 7'b1101110;
  localparam logic [6:0] COD_TERM9  = 7'b1001001;
  localparam logic [6:0] COD_TERM10 = 7'b1010011;
  localparam logic [6:0] COD_ERRO   = 7'b1110101;

  // Tracked decoder state encodings
  localparam logic [3:0] POS_ZERO       = 4'd0;
  localparam logic [3:0] POS_MIN        = 4'd1;
  localparam logic [3:0] POS_MAX        = 4'd5;
  localparam logic [3:0] POS_ERRO       = 4'd8;
  localparam logic [3:0] POS_TERM_BAIXO = 4'd9;
  localparam logic [3:0] POS_TERM_ALTO  = 4'd10;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    EMITE  = 3'd1,
    PAUSA  = 3'd2,
    FIM    = 3'd3,
    ERRO   = 3'd4
  } estado_t;

  // Code word that moves the decoder into state p
  function automatic logic [6:0] codigo_de(input logic [3:0] p);
    logic [6:0] c;
    case (p)
      4'd1:           c = COD_POS1;
      4'd2:           c = COD_POS2;
      4'd3:           c = COD_POS3;
      4'd4:           c = COD_POS4;
      4'd5:           c = COD_POS5;
      POS_TERM_BAIXO: c = COD_TERM9;
      POS_TERM_ALTO:  c = COD_TERM10;
      POS_ERRO:       c = COD_ERRO;
      default:        c = 7'b0000000;
    endcase
    return c;
  endfunction

  // Positions 1..5 are the only ones from which stepping or aborting is possible
  function automatic logic pos_movel(input logic [3:0] p);
    return (p >= POS_MIN) && (p <= POS_MAX);
  endfunction

  // Legal command targets: positions 1..5 and the two terminate codes
  function automatic logic alvo_legal(input logic [3:0] a);
    return pos_movel(a) || (a == POS_TERM_BAIXO) || (a == POS_TERM_ALTO);
  endfunction

endpackage

// File: rtl/codificador_passo.sv
// Combinational step planner: given the current decoder state and the
// command target, returns the next state to move to and its code word.
module codificador_passo
  import codificador_pkg::*;
(
  input  logic [3:0] posicao,
  input  logic [3:0] alvo,
  output logic [3:0] prox_posicao,
  output logic [6:0] prox_codigo
);

  // Choose the next decoder state: direct jump from 0, adjacent steps otherwise
  always_comb begin
    prox_posicao = posicao;
    if (posicao == POS_ZERO) begin
      case (alvo)
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5: prox_posicao = alvo;
        POS_TERM_BAIXO:               prox_posicao = 4'd3;
        POS_TERM_ALTO:                prox_posicao = 4'd4;
        default:                      prox_posicao = posicao;
      endcase
    end else if (pos_movel(posicao)) begin
      case (alvo)
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
          if (alvo > posicao) begin
            prox_posicao = posicao + 4'd1;
          end else if (alvo < posicao) begin
            prox_posicao = posicao - 4'd1;
          end else begin
            prox_posicao = posicao;
          end
        end
        POS_TERM_BAIXO: begin
          if (posicao > 4'd3) begin
            prox_posicao = posicao - 4'd1;
          end else begin
            prox_posicao = POS_TERM_BAIXO;
          end
        end
        POS_TERM_ALTO: begin
          if (posicao < 4'd4) begin
            prox_posicao = posicao + 4'd1;
          end else begin
            prox_posicao = POS_TERM_ALTO;
          end
        end
        default: prox_posicao = posicao;
      endcase
    end else begin
      prox_posicao = posicao;
    end
  end

  assign prox_codigo = codigo_de(prox_posicao);

endmodule

// File: rtl/codificador_maq.sv
// Command controller that walks the decoder to a target position by
// emitting one code word per EMITE cycle, each followed by a PAUSA cycle.
module codificador_maq
  import codificador_pkg::*;
(
  input  logic       clk,
  input  logic       Reset,
  input  logic       Pedido,
  input  logic [3:0] Alvo,
  input  logic       Aborta,
  output logic [6:0] Codigo,
  output logic       Valido,
  output logic [3:0] Posicao,
  output logic       Pronto,
  output logic       Concluido,
  output logic       Rejeitado
);

  estado_t    estado_r, estado_nx_s;
  logic [3:0] posicao_r, posicao_nx_s;
  logic [3:0] pend_r, pend_nx_s;       // state the decoder enters when EMITE closes
  logic [3:0] alvo_r, alvo_nx_s;
  logic [6:0] codigo_r, codigo_nx_s;
  logic       valido_r, valido_nx_s;
  logic       pronto_r, pronto_nx_s;
  logic       concluido_r, concluido_nx_s;
  logic       rejeitado_r, rejeitado_nx_s;
  logic       pronto_s;
  logic [3:0] passo_alvo_s, passo_pos_s;
  logic [6:0] passo_cod_s;

  // Acceptance uses the live state so a command can be taken right after reset
  assign pronto_s     = (estado_r == OCIOSO) && (posicao_r <= POS_MAX);
  // New commands plan from the input target, running ones from the stored target
  assign passo_alvo_s = (estado_r == OCIOSO) ? Alvo : alvo_r;

  codificador_passo u_passo (
    .posicao      (posicao_r),
    .alvo         (passo_alvo_s),
    .prox_posicao (passo_pos_s),
    .prox_codigo  (passo_cod_s)
  );

  // Next-state and next-output decision
  always_comb begin
    estado_nx_s    = estado_r;
    posicao_nx_s   = posicao_r;
    pend_nx_s      = pend_r;
    alvo_nx_s      = alvo_r;
    codigo_nx_s    = 7'b0000000;
    valido_nx_s    = 1'b0;
    concluido_nx_s = 1'b0;
    rejeitado_nx_s = 1'b0;
    case (estado_r)
      OCIOSO: begin
        if (Aborta && pos_movel(posicao_r)) begin
          estado_nx_s = EMITE;
          pend_nx_s   = POS_ERRO;
          codigo_nx_s = COD_ERRO;
          valido_nx_s = 1'b1;
        end else if (Pedido && !Aborta && pronto_s) begin
          if (!alvo_legal(Alvo)) begin
            rejeitado_nx_s = 1'b1;
          end else if (Alvo == posicao_r) begin
            concluido_nx_s = 1'b1;
          end else begin
            estado_nx_s = EMITE;
            alvo_nx_s   = Alvo;
            pend_nx_s   = passo_pos_s;
            codigo_nx_s = passo_cod_s;
            valido_nx_s = 1'b1;
          end
        end else begin
          estado_nx_s = OCIOSO;
        end
      end
      EMITE: begin
        estado_nx_s  = PAUSA;
        posicao_nx_s = pend_r;
      end
      PAUSA: begin
        if (posicao_r == POS_ERRO) begin
          estado_nx_s = ERRO;
        end else if ((posicao_r == POS_TERM_BAIXO) || (posicao_r == POS_TERM_ALTO)) begin
          estado_nx_s = FIM;
        end else if (Aborta && pos_movel(posicao_r)) begin
          estado_nx_s = EMITE;
          pend_nx_s   = POS_ERRO;
          codigo_nx_s = COD_ERRO;
          valido_nx_s = 1'b1;
        end else if (posicao_r == alvo_r) begin
          estado_nx_s    = OCIOSO;
          concluido_nx_s = 1'b1;
        end else begin
          estado_nx_s = EMITE;
          pend_nx_s   = passo_pos_s;
          codigo_nx_s = passo_cod_s;
          valido_nx_s = 1'b1;
        end
      end
      FIM:     estado_nx_s = FIM;
      ERRO:    estado_nx_s = ERRO;
      default: estado_nx_s = OCIOSO;
    endcase
    pronto_nx_s = (estado_nx_s == OCIOSO) && (posicao_nx_s <= POS_MAX);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      estado_r    <= OCIOSO;
      posicao_r   <= POS_ZERO;
      pend_r      <= POS_ZERO;
      alvo_r      <= POS_ZERO;
      codigo_r    <= 7'b0000000;
      valido_r    <= 1'b0;
      pronto_r    <= 1'b0;
      concluido_r <= 1'b0;
      rejeitado_r <= 1'b0;
    end else begin
      estado_r    <= estado_nx_s;
      posicao_r   <= posicao_nx_s;
      pend_r      <= pend_nx_s;
      alvo_r      <= alvo_nx_s;
      codigo_r    <= codigo_nx_s;
      valido_r    <= valido_nx_s;
      pronto_r    <= pronto_nx_s;
      concluido_r <= concluido_nx_s;
      rejeitado_r <= rejeitado_nx_s;
    end
  end

  assign Codigo    = codigo_r;
  assign Valido    = valido_r;
  assign Posicao   = posicao_r;
  assign Pronto    = pronto_r;
  assign Concluido = concluido_r;
  assign Rejeitado = rejeitado_r;

endmodule

// File: doc/codificador_maq.md
CODIFICADOR_MAQ -- requirements
Module: codificador_maq

Interface
REQ-001 clk  input  1  single clock; all state changes on posedge clk.
REQ-002 Reset  input  1  asynchronous, active-low reset.
REQ-003 Pedido  input  1  command request; accepted only when Pronto=1.
REQ-004 Alvo  input  4  target: 1..5 = position, 9 = terminate-low, 10 = terminate-high.
REQ-005 Aborta  input  1  request error emission; higher priority than Pedido.
REQ-006 Codigo  output  7  code word; 7'b0000000 whenever Valido=0.
REQ-007 Valido  output  1  one-cycle strobe qualifying Codigo; drives the decoder's Controle.
REQ-008 Posicao  output  4  tracked decoder state: 0, 1..5, 8 (error), 9, 10.
REQ-009 Pronto  output  1  high iff in OCIOSO state and Posicao in {0..5}.
REQ-010 Concluido  output  1  one-cycle pulse when a command completes.
REQ-011 Rejeitado  output  1  one-cycle pulse when a Pedido carries an illegal Alvo.

Function
REQ-012 Code table: pos1 1100000, pos2 1000100, pos3 1111100, pos4 1011010, pos5 1101110, term9 1001001, term10 1010011, error 1110101.
REQ-013 States: OCIOSO, EMITE, PAUSA, FIM, ERRO. Valido=1 only in EMITE; EMITE always lasts exactly one cycle and is followed by one PAUSA cycle.
REQ-014 Accept: Pedido=1, Pronto=1, Aborta=0 at edge k; Alvo in {0,6,7,8,11..15} -> no accept, Rejeitado=1 in cycle k+1, stays OCIOSO.
REQ-015 From Posicao=0, a legal position target is reached in one emission (direct jump); terminate targets from 0 first jump to 3 (Alvo=9) or 4 (Alvo=10).
REQ-016 From Posicao 1..5, moves are single adjacent steps (±1) toward the target, one code word per EMITE.
REQ-017 Alvo=9 from 4 or 5: step down to 3, then emit term9; from 1..3, emit term9 directly. Alvo=10 from 1..3: step up to 4, then emit term10; from 4 or 5, emit term10 directly.
REQ-018 Posicao updates at the edge closing each EMITE cycle to the position/terminal/error value of the emitted code.
REQ-019 First EMITE in cycle k+1 after acceptance; the n-th emission is in cycle k+2n-1; after the last PAUSA, return to OCIOSO with Concluido=1 in that first OCIOSO cycle.
REQ-020 Alvo equal to Posicao: accepted, no emission, Concluido=1 in cycle k+1.
REQ-021 After a terminal code: state FIM, Pronto=0, Pedido ignored until Reset.
REQ-022 Aborta sampled in OCIOSO or PAUSA with Posicao in 1..5: the next cycle is EMITE with the error code, any pending command is dropped (no Concluido), then ERRO, sticky, Posicao=8.
REQ-023 Aborta with Posicao=0, in FIM, or in ERRO: ignored, no emission.
REQ-024 Aborta and Pedido in the same cycle: Aborta wins, Pedido not accepted, no Rejeitado.

Reset
REQ-025 Reset=0 asynchronously forces OCIOSO, Posicao=0, Codigo=0, Valido=0, Concluido=0, Rejeitado=0; Pronto=1 once reset is released.
REQ-026 Reset mid-command aborts with no further emissions; the next command starts from Posicao=0.

Structure
REQ-027 Package codificador_pkg holds the eight code-word constants, Posicao encodings (0, 1..5, 8, 9, 10) and the state enumeration.
REQ-028 One sub-module, codificador_passo (combinational): inputs Posicao and Alvo, outputs the next Posicao and its code word per REQ-015..017.

Verification
REQ-029 Reset, then Pedido Alvo=3 -> Codigo 1111100 with Valido in cycle k+1, Posicao=3, Concluido in cycle k+3.
REQ-030 From 1, Alvo=5 -> codes 1000100, 1111100, 1011010, 1101110 in cycles k+1, k+3, k+5, k+7; Concluido in cycle k+9.
REQ-031 From 5, Alvo=9 -> 1011010, 1111100, 1001001; Posicao=9; Pronto=0; a further Pedido is ignored.
REQ-032 Move 1->4 with Aborta raised in the first PAUSA -> next cycle Codigo 1110101; Posicao=8; no Concluido.
REQ-033 Alvo=7 -> Rejeitado pulse, no Valido; Pedido and Aborta together at Posicao=0 -> no response.
REQ-034 Reset pulse between two emissions -> all outputs 0 immediately; next Alvo=2 emits 1000100 in one step.
